// File: rtl/risc_v_mike_pkg.sv
// Shared memory-map constants and types for the load/store data-bus router.
// Default region table matches the simulator memory map (text, data, stack, MMIO).
package risc_v_mike_pkg;

    localparam logic [31:0] MEM_MAP_TEXT_LOWER_LIMIT  = 32'h0040_0000;
    localparam logic [31:0] MEM_MAP_TEXT_UPPER_LIMIT  = 32'h0FFF_FFFF;
    localparam logic [31:0] MEM_MAP_DATA_LOWER_LIMIT  = 32'h1001_0000;
    localparam logic [31:0] MEM_MAP_DATA_UPPER_LIMIT  = 32'h1003_FFFF;
    localparam logic [31:0] MEM_MAP_STACK_LOWER_LIMIT = 32'h7FFF_0000;
    localparam logic [31:0] MEM_MAP_STACK_UPPER_LIMIT = 32'h7FFF_FFFF;
    localparam logic [31:0] MEM_MAP_MMIO_LOWER_LIMIT  = 32'hFFFF_0000;
    localparam logic [31:0] MEM_MAP_MMIO_UPPER_LIMIT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_router_state_e;

    // Wide enough for the maximum of eight regions.
    typedef logic [2:0] mem_region_idx_t;

endpackage

// File: rtl/risc_v_mem_router_if.sv
// Bus bundle between the load/store unit, the router and the memory regions.
// slave = router view, master = LSU/region/test view.
interface risc_v_mem_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic                          req_val;
    logic                          req_rdy;
    logic                          req_we;
    logic [ADDR_W-1:0]             req_addr;
    logic [DATA_W-1:0]             req_wdata;
    logic                          rsp_val;
    logic                          rsp_rdy;
    logic [DATA_W-1:0]             rsp_rdata;
    logic                          rsp_err;
    logic [NUM_REGIONS-1:0]        reg_sel;
    logic                          reg_we;
    logic [ADDR_W-1:0]             reg_addr;
    logic [DATA_W-1:0]             reg_wdata;
    logic [NUM_REGIONS*DATA_W-1:0] reg_rdata;
    logic                          err_val;
    logic [ADDR_W-1:0]             err_addr;
    logic                          err_we;
    logic                          err_clr;

    modport slave (
        input  req_val, req_we, req_addr, req_wdata, rsp_rdy, reg_rdata, err_clr,
        output req_rdy, rsp_val, rsp_rdata, rsp_err, reg_sel, reg_we, reg_addr,
               reg_wdata, err_val, err_addr, err_we
    );

    modport master (
        output req_val, req_we, req_addr, req_wdata, rsp_rdy, reg_rdata, err_clr,
        input  req_rdy, rsp_val, rsp_rdata, rsp_err, reg_sel, reg_we, reg_addr,
               reg_wdata, err_val, err_addr, err_we
    );

endinterface

// File: rtl/risc_v_mem_region_match.sv
// Combinational priority matcher: inclusive unsigned base/limit compare,
// lowest-numbered region wins on overlap; also yields the region-relative offset.
module risc_v_mem_region_match
    import risc_v_mike_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [ADDR_W-1:0]      base_i  [NUM_REGIONS],
    input  logic [ADDR_W-1:0]      limit_i [NUM_REGIONS],
    output logic                   hit_o,
    output logic [NUM_REGIONS-1:0] sel_o,
    output mem_region_idx_t        idx_o,
    output logic [ADDR_W-1:0]      offset_o
);

    // Scan from the top down so the last assignment belongs to the lowest index.
    always_comb begin
        hit_o    = 1'b0;
        sel_o    = '0;
        idx_o    = '0;
        offset_o = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr_i >= base_i[i]) && (addr_i <= limit_i[i])) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                idx_o    = mem_region_idx_t'(i);
                offset_o = addr_i - base_i[i];
            end
        end
    end

endmodule

// File: rtl/risc_v_mem_router.sv
// Registered data-bus router: region decode, wait-stated strobe, response and sticky error.
// Optional build macro MEM_ROUTER_ALIGN_CHECK_EN turns misaligned word accesses into errors.
module risc_v_mem_router
    import risc_v_mike_pkg::*;
#(
    parameter int               NUM_REGIONS = 4,
    parameter int               ADDR_W      = 32,
    parameter int               DATA_W      = 32,
    parameter int               WAIT_W      = 4,
    parameter logic [ADDR_W-1:0] REGION_BASE  [NUM_REGIONS] = '{
        MEM_MAP_TEXT_LOWER_LIMIT, MEM_MAP_DATA_LOWER_LIMIT,
        MEM_MAP_STACK_LOWER_LIMIT, MEM_MAP_MMIO_LOWER_LIMIT},
    parameter logic [ADDR_W-1:0] REGION_LIMIT [NUM_REGIONS] = '{
        MEM_MAP_TEXT_UPPER_LIMIT, MEM_MAP_DATA_UPPER_LIMIT,
        MEM_MAP_STACK_UPPER_LIMIT, MEM_MAP_MMIO_UPPER_LIMIT},
    parameter logic [WAIT_W-1:0] REGION_WAIT  [NUM_REGIONS] = '{4'd0, 4'd0, 4'd0, 4'd2}
) (
    input  logic                clk,
    input  logic                rst,
    risc_v_mem_router_if.slave  bus
);

    mem_router_state_e      state_q;
    logic                   req_rdy_q;
    logic                   rsp_val_q;
    logic                   rsp_err_q;
    logic [DATA_W-1:0]      rsp_rdata_q;
    logic [NUM_REGIONS-1:0] reg_sel_q;
    logic                   reg_we_q;
    logic [ADDR_W-1:0]      reg_addr_q;
    logic [DATA_W-1:0]      reg_wdata_q;
    logic [WAIT_W-1:0]      wait_q;
    mem_region_idx_t        idx_q;
    logic                   err_val_q;
    logic [ADDR_W-1:0]      err_addr_q;
    logic                   err_we_q;

    logic                   hit_d;
    logic [NUM_REGIONS-1:0] sel_d;
    mem_region_idx_t        idx_d;
    logic [ADDR_W-1:0]      offset_d;
    logic                   miss_d;
    logic [WAIT_W-1:0]      wait_d;
    logic [DATA_W-1:0]      rdata_d;
    logic                   accept_d;

    logic [ADDR_W-1:0] base_tbl  [NUM_REGIONS];
    logic [ADDR_W-1:0] limit_tbl [NUM_REGIONS];

    assign base_tbl  = REGION_BASE;
    assign limit_tbl = REGION_LIMIT;

    risc_v_mem_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W)
    ) u_match (
        .addr_i   (bus.req_addr),
        .base_i   (base_tbl),
        .limit_i  (limit_tbl),
        .hit_o    (hit_d),
        .sel_o    (sel_d),
        .idx_o    (idx_d),
        .offset_o (offset_d)
    );

`ifdef MEM_ROUTER_ALIGN_CHECK_EN
    assign miss_d = !hit_d || (bus.req_addr[1:0] != 2'b00);
`else
    assign miss_d = !hit_d;
`endif

    always_comb begin
        wait_d = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_d[i]) wait_d = REGION_WAIT[i];
        end
    end

    assign rdata_d  = DATA_W'(bus.reg_rdata >> (int'(idx_q) * DATA_W));
    assign accept_d = bus.req_val && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_rdy_q   <= 1'b1;
            rsp_val_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            reg_sel_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            wait_q      <= '0;
            idx_q       <= '0;
            err_val_q   <= 1'b0;
            err_addr_q  <= '0;
            err_we_q    <= 1'b0;
        end else begin
            // A clear coinciding with a new miss still captures the new fault.
            if (accept_d && miss_d && (!err_val_q || bus.err_clr)) begin
                err_val_q  <= 1'b1;
                err_addr_q <= bus.req_addr;
                err_we_q   <= bus.req_we;
            end else if (bus.err_clr) begin
                err_val_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.req_val) begin
                        req_rdy_q <= 1'b0;
                        if (miss_d) begin
                            state_q     <= RESP;
                            rsp_val_q   <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ACCESS;
                            reg_sel_q   <= sel_d;
                            reg_we_q    <= bus.req_we;
                            reg_addr_q  <= offset_d;
                            reg_wdata_q <= bus.req_wdata;
                            wait_q      <= wait_d;
                            idx_q       <= idx_d;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_q == '0) begin
                        state_q     <= RESP;
                        reg_sel_q   <= '0;
                        reg_we_q    <= 1'b0;
                        rsp_val_q   <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= reg_we_q ? '0 : rdata_d;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_rdy) begin
                        state_q     <= IDLE;
                        req_rdy_q   <= 1'b1;
                        rsp_val_q   <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_rdy   = req_rdy_q;
    assign bus.rsp_val   = rsp_val_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.reg_sel   = reg_sel_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.err_val   = err_val_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_we    = err_we_q;

endmodule

// File: tb/tb_risc_v_mem_router.sv
// Self-checking bench for risc_v_mem_router: directed cases plus randomized
// transactions against a table-lookup reference model.
module tb_risc_v_mem_router;
    import risc_v_mike_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_v_mem_router_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    risc_v_mem_router #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference memory map and wait table.
    logic [31:0] m_base [NR] = '{MEM_MAP_TEXT_LOWER_LIMIT, MEM_MAP_DATA_LOWER_LIMIT,
                                 MEM_MAP_STACK_LOWER_LIMIT, MEM_MAP_MMIO_LOWER_LIMIT};
    logic [31:0] m_lim  [NR] = '{MEM_MAP_TEXT_UPPER_LIMIT, MEM_MAP_DATA_UPPER_LIMIT,
                                 MEM_MAP_STACK_UPPER_LIMIT, MEM_MAP_MMIO_UPPER_LIMIT};
    int          m_wait [NR] = '{0, 0, 0, 2};
    logic [DW-1:0] rd_tbl [NR];

    bit          m_ev;
    logic [31:0] m_ea;
    bit          m_ew;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lookup(input logic [31:0] a);
        for (int i = 0; i < NR; i++)
            if (a >= m_base[i] && a <= m_lim[i]) return i;
        return -1;
    endfunction

    task automatic drive_rdata();
        for (int i = 0; i < NR; i++) bus.reg_rdata[i*DW +: DW] = rd_tbl[i];
    endtask

    task automatic check_err_model(input string tag);
        chk({tag, "_err_val"}, bus.err_val, m_ev);
        if (m_ev) begin
            chk({tag, "_err_addr"}, bus.err_addr, m_ea);
            chk({tag, "_err_we"}, bus.err_we, m_ew);
        end
    endtask

    // One full transaction; entered and left on a falling edge.
    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit clr, input int hold, input bit poke);
        int r;
        bit miss;
        logic [NR-1:0] oh;
        logic [31:0] exp_rd;
        bit exp_err;
        r = lookup(a);
        miss = (r < 0);
`ifdef MEM_ROUTER_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) miss = 1'b1;
`endif
        for (int i = 0; i < NR; i++) rd_tbl[i] = $urandom;
        drive_rdata();
        chk("idle_rdy", bus.req_rdy, 1'b1);
        bus.req_val   = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.err_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        bus.req_val   = 1'b0;
        bus.err_clr   = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        if (miss && (!m_ev || clr)) begin
            m_ev = 1'b1; m_ea = a; m_ew = we;
        end else if (clr) begin
            m_ev = 1'b0;
        end

        if (!miss) begin
            oh = '0;
            oh[r] = 1'b1;
            for (int k = 0; k <= m_wait[r]; k++) begin
                chk("strobe_sel", bus.reg_sel, oh);
                chk("strobe_we", bus.reg_we, we);
                chk("strobe_addr", bus.reg_addr, a - m_base[r]);
                chk("strobe_wdata", bus.reg_wdata, wd);
                chk("rsp_early", bus.rsp_val, 1'b0);
                chk("busy_rdy", bus.req_rdy, 1'b0);
                @(negedge clk);
            end
            exp_rd  = we ? 32'h0 : rd_tbl[r];
            exp_err = 1'b0;
        end else begin
            exp_rd  = 32'h0;
            exp_err = 1'b1;
        end

        chk("rsp_val", bus.rsp_val, 1'b1);
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("sel_after", bus.reg_sel, '0);
        check_err_model("txn");

        for (int h = 0; h < hold; h++) begin
            for (int i = 0; i < NR; i++) rd_tbl[i] = $urandom;
            drive_rdata();
            if (poke) begin
                bus.req_val  = 1'b1;
                bus.req_addr = m_base[$urandom_range(0, NR-1)];
            end
            @(negedge clk);
            chk("hold_val", bus.rsp_val, 1'b1);
            chk("hold_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_err", bus.rsp_err, exp_err);
            chk("hold_rdy", bus.req_rdy, 1'b0);
            chk("hold_sel", bus.reg_sel, '0);
        end
        bus.req_val = 1'b0;
        bus.rsp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_rdy = 1'b0;
        chk("done_val", bus.rsp_val, 1'b0);
        chk("done_rdy", bus.req_rdy, 1'b1);
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_ev = 1'b0;
        chk("clr_err_val", bus.err_val, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, bus.req_rdy, 1'b1);
        chk({tag, "_rsp_val"}, bus.rsp_val, 1'b0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
        chk({tag, "_sel"}, bus.reg_sel, '0);
        chk({tag, "_we"}, bus.reg_we, 1'b0);
        chk({tag, "_addr"}, bus.reg_addr, '0);
        chk({tag, "_wdata"}, bus.reg_wdata, '0);
        chk({tag, "_err_val"}, bus.err_val, 1'b0);
        chk({tag, "_err_addr"}, bus.err_addr, '0);
        chk({tag, "_err_we"}, bus.err_we, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        rst           = 1'b1;
        bus.req_val   = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_rdy   = 1'b0;
        bus.err_clr   = 1'b0;
        for (int i = 0; i < NR; i++) rd_tbl[i] = $urandom;
        drive_rdata();
        m_ev = 1'b0; m_ea = '0; m_ew = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Directed: data read, MMIO write with wait states, misses and error register.
        txn(1'b0, 32'h1001_0008, 32'h0, 1'b0, 0, 1'b0);
        txn(1'b1, 32'hFFFF_0004, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 0, 1'b0);
        txn(1'b1, 32'h0000_0020, 32'h1234, 1'b0, 0, 1'b0);
        chk("sticky_addr", bus.err_addr, 32'h0000_0010);
        clear_err();

        // Response back-pressure with ignored requests, then immediate re-accept.
        txn(1'b0, 32'h7FFF_0100, 32'h0, 1'b0, 5, 1'b1);
        txn(1'b0, 32'h0040_0000, 32'h0, 1'b0, 0, 1'b0);

        // Clear and a new miss in the same cycle: the new fault is captured.
        txn(1'b0, 32'h0000_0040, 32'h0, 1'b0, 0, 1'b0);
        txn(1'b1, 32'h0000_0080, 32'h5, 1'b1, 0, 1'b0);
        chk("clr_miss_addr", bus.err_addr, 32'h0000_0080);
        clear_err();

        // Boundaries: inclusive limits, top of address space, one past/below a region.
        txn(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h1003_FFFC, 32'h0, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h1004_0000, 32'h0, 1'b0, 0, 1'b0);
        clear_err();
        txn(1'b0, 32'h003F_FFFC, 32'h0, 1'b0, 0, 1'b0);
        clear_err();
        txn(1'b0, 32'h1001_0002, 32'h0, 1'b0, 1, 1'b0);
        clear_err();

        // Reset during the access phase of an MMIO write drops the request.
        bus.req_val   = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'hFFFF_0008;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_val = 1'b0;
        chk("pre_rst_sel", bus.reg_sel, 4'b1000);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        m_ev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", bus.rsp_val, 1'b0);
        end

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: begin
                    r = $urandom_range(0, NR-1);
                    a = m_lim[r] - ($urandom_range(0, 15) << 2);
                end
                default: begin
                    r = $urandom_range(0, NR-1);
                    a = m_base[r] + ($urandom_range(0, 255) << 2);
                end
            endcase
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            txn(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) == 0),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/risc_v_mem_router.md
Name: risc_v_mem_router

Overview:
- Parametrised, registered successor to the single-cycle data-bus address decoder.
- Sits between the core's load/store unit and the memory regions (text, data, stack, MMIO).
- Accepts one request at a time over a valid/ready handshake and selects a region from a parameter table.
- Per region: issues a strobe with offset address, applies a configurable wait-state count, and returns read data or an error response.
- A sticky error register records the first unmapped access.

Parameters:
- NUM_REGIONS, 4, number of address regions (1..8).
- ADDR_W, 32, request address width.
- DATA_W, 32, data width.
- WAIT_W, 4, wait-counter width.
- REGION_BASE, {TEXT,DATA,STACK,MMIO} lower limits from package, per-region inclusive base address.
- REGION_LIMIT, matching package upper limits, per-region inclusive limit address.
- REGION_WAIT, {0,0,0,2}, per-region extra wait cycles (0..2^WAIT_W-1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  router ready to accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_val  out  1  response valid.
- rsp_rdy  in  1  response accepted.
- rsp_rdata  out  DATA_W  read data (0 on write or error).
- rsp_err  out  1  response carries an error.
- reg_sel  out  NUM_REGIONS  one-hot region strobe.
- reg_we  out  1  write strobe qualifier.
- reg_addr  out  ADDR_W  offset address (req_addr - REGION_BASE[i]).
- reg_wdata  out  DATA_W  write data to region.
- reg_rdata  in  NUM_REGIONS*DATA_W  per-region read data, region i in slice i.
- err_val  out  1  sticky error flag.
- err_addr  out  ADDR_W  captured faulting address.
- err_we  out  1  captured direction.
- err_clr  in  1  clears the sticky error.

Behaviour:
- Reset values: state IDLE; req_rdy=1; rsp_val=0; rsp_err=0; rsp_rdata=0; reg_sel=0; reg_we=0; reg_addr=0; reg_wdata=0; wait counter=0; err_val=0; err_addr=0; err_we=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_rdy=1. On req_val, latch we/addr/wdata and decode.
  - Region i hits when BASE[i] <= addr <= LIMIT[i], unsigned compare. On overlapping hits, the lowest index wins.
  - Hit: go to ACCESS; counter loads REGION_WAIT[i].
  - Miss: go to RESP with rsp_err=1 and no strobe.
- ACCESS:
  - req_rdy=0. reg_sel one-hot and reg_we/reg_addr/reg_wdata held stable.
  - Counter decrements each cycle.
  - When counter==0: sample reg_rdata of the selected region (reads only), drop reg_sel, go to RESP.
  - Strobe width is REGION_WAIT+1 cycles. A write therefore commits exactly once per strobe cycle; regions must treat strobe as a level write enable, which is idempotent for the same data.
- RESP:
  - rsp_val=1; rsp_rdata/rsp_err held stable until rsp_rdy.
  - On rsp_rdy, go to IDLE. A new request is accepted the next cycle (no back-to-back overlap).
- Latency, req accept to rsp_val: hit = WAIT+2 cycles; miss = 1 cycle.
- Error register:
  - On a miss with err_val=0, capture addr/we and set err_val.
  - Later errors do not overwrite the captured values.
  - err_clr clears err_val. If err_clr and a new miss occur in the same cycle, the new error is captured (err_val stays 1).
- Reset asserted mid-ACCESS or mid-RESP: all outputs return to reset values asynchronously; the in-flight request is dropped with no response.
- Address 0xFFFFFFFF and region-limit equality are inclusive; no wrap arithmetic beyond ADDR_W (offset computed modulo 2^ADDR_W).

Optional Feature:
- Macro: MEM_ROUTER_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0] != 0 is treated as a miss (rsp_err=1, error capture, no strobe), even when inside a region.
- Undefined: alignment is ignored; only the region decode can produce errors.

Decomposition:
- Shared package (risc_v_mike_pkg) holds:
  - MEM_MAP_*_LOWER/UPPER_LIMIT constants, reused as default REGION_BASE/LIMIT.
  - Typedef mem_router_state_e {IDLE, ACCESS, RESP}.
  - Typedef mem_region_idx_t.
- One sub-module: risc_v_mem_region_match — combinational priority matcher producing hit, one-hot select and index from addr plus base/limit arrays.

Test Plan:
- Read 0x10010008 (DATA, wait 0): reg_sel=0010, reg_addr=0x8 for 1 cycle; rsp_val 2 cycles after accept with rsp_rdata=DATA slice value, rsp_err=0.
- Write 0xFFFF0004 (MMIO, wait 2): reg_sel=1000, reg_we=1, reg_addr=0x4 held 3 cycles; rsp_val at cycle 4, rsp_rdata=0.
- Read 0x00000010 (unmapped): rsp_val next cycle with rsp_err=1; err_val=1, err_addr=0x00000010, err_we=0. A second miss at 0x20 leaves err_addr=0x10; err_clr then drops err_val.
- Hold rsp_rdy=0 for 5 cycles: rsp_val/rsp_rdata stable, req_rdy=0, a new req_val is ignored. rsp_rdy=1 returns to IDLE and the request is accepted next cycle.
- Assert rst during ACCESS of an MMIO write: reg_sel=0, rsp_val=0, req_rdy=1 immediately; no response is produced.
- With MEM_ROUTER_ALIGN_CHECK_EN: read 0x10010002 gives rsp_err=1 and no strobe. Without the macro, the same read hits DATA with reg_addr=0x2.
